mem_lsu_stage: RTL

Parametrised memory-access pipeline stage for the five-stage core. It sits between the EX/MEM and MEM/WB pipeline registers and absorbs the MEM/WB register into its own output flops. It replaces the single-cycle word-only memory stage with full byte, halfword and word loads and stores, byte-lane selects and alignment exceptions. It also runs a req/ack handshake to a data memory with variable latency, stalling the pipeline until the access completes or times out.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 51 +++++
 rtl/mem_lsu_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - memory-op codes, LSU FSM states and op classification helpers
package mem_pkg;

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0,
    MOP_LB   = 4'd1,
    MOP_LBU  = 4'd2,
    MOP_LH   = 4'd3,
    MOP_LHU  = 4'd4,
    MOP_LW   = 4'd5,
    MOP_SB   = 4'd6,
    MOP_SH   = 4'd7,
    MOP_SW   = 4'd8
  } memop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MOP_LB) || (op == MOP_LBU) || (op == MOP_LH) ||
           (op == MOP_LHU) || (op == MOP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW);
  endfunction

  // Codes 9..15 are unassigned and classify as neither load nor store.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    logic m;
    case (op)
      MOP_LH, MOP_LHU, MOP_SH: m = addr_lo[0];
      MOP_LW, MOP_SW:          m = |addr_lo;
      default:                 m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane select, store replication and load extraction/extension
module lsu_align
  import mem_pkg::*;
(
  input  logic [3:0]  memop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    sel_o     = 4'b0000;
    st_data_o = rt_i;
    ld_data_o = rdata_i;
    case (memop_i)
      MOP_LB, MOP_LBU, MOP_SB: sel_o = 4'b0001 << addr_lo_i;
      MOP_LH, MOP_LHU, MOP_SH: sel_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      MOP_LW, MOP_SW:          sel_o = 4'b1111;
      default:                 sel_o = 4'b0000;
    endcase
    case (memop_i)
      MOP_SB:  st_data_o = {4{rt_i[7:0]}};
      MOP_SH:  st_data_o = {2{rt_i[15:0]}};
      default: st_data_o = rt_i;
    endcase
    case (memop_i)
      MOP_LB:  ld_data_o = {{24{byte_v[7]}}, byte_v};
      MOP_LBU: ld_data_o = {24'd0, byte_v};
      MOP_LH:  ld_data_o = {{16{half_v[15]}}, half_v};
      MOP_LHU: ld_data_o = {16'd0, half_v};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu_stage.sv
// rtl/mem_lsu_stage.sv - MEM pipeline stage: req/ack data-memory access, alignment
// exceptions, timeout bus errors and the MEM/WB output register
module mem_lsu_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [3:0]        memop_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  output logic              dm_req_o,
  output logic              dm_we_o,
  output logic [3:0]        dm_sel_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [DATA_W-1:0] dm_wdata_o,
  input  logic [DATA_W-1:0] dm_rdata_i,
  input  logic              dm_ack_i,
  output logic              stall_o,
  output logic              wb_valid_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic              exc_o,
  output logic [ADDR_W-1:0] badaddr_o,
  output logic              buserr_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [3:0]        dm_sel_q, dm_sel_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d, badaddr_q, badaddr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d, wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d, wreg_q, wreg_d;
  logic [REG_AW-1:0] wd_q, wd_d;
  logic              exc_q, exc_d, buserr_q, buserr_d;
  logic              stall_c;

  logic [3:0]  lane_sel;
  logic [31:0] st_data, ld_data;
  logic        is_mem, mis, go, expire;

  lsu_align u_align (
    .memop_i   (memop_i),
    .addr_lo_i (mem_addr_i[1:0]),
    .rt_i      (reg2_i),
    .rdata_i   (dm_rdata_i),
    .sel_o     (lane_sel),
    .st_data_o (st_data),
    .ld_data_o (ld_data)
  );

  assign is_mem = valid_i && (is_load(memop_i) || is_store(memop_i));
  assign mis    = is_mem && misaligned(memop_i, mem_addr_i[1:0]);
  assign go     = is_mem && !mis;
  // Expiry falls on the WAIT cycle after TIMEOUT ack-less cycles; an ack there still wins.
  assign expire = (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_sel_q   <= 4'b0000;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      wb_valid_q <= 1'b0;
      wdata_q    <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      exc_q      <= 1'b0;
      badaddr_q  <= '0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_sel_q   <= dm_sel_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      wb_valid_q <= wb_valid_d;
      wdata_q    <= wdata_d;
      wd_q       <= wd_d;
      wreg_q     <= wreg_d;
      exc_q      <= exc_d;
      badaddr_q  <= badaddr_d;
      buserr_q   <= buserr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_WAIT;
      ST_WAIT: if (dm_ack_i || expire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_c    = 1'b0;
    cnt_d      = '0;
    dm_req_d   = 1'b0;
    dm_we_d    = dm_we_q;
    dm_sel_d   = dm_sel_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    wb_valid_d = 1'b0;
    wdata_d    = '0;
    wd_d       = wd_i;
    wreg_d     = 1'b0;
    exc_d      = 1'b0;
    badaddr_d  = badaddr_q;
    buserr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          stall_c    = 1'b1;
          dm_req_d   = 1'b1;
          dm_we_d    = is_store(memop_i);
          dm_sel_d   = lane_sel;
          dm_addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
          dm_wdata_d = st_data;
        end else begin
          wb_valid_d = valid_i;
          wreg_d     = valid_i && wreg_i && !is_mem;
          wdata_d    = is_mem ? '0 : wdata_i;
          if (mis) begin
            exc_d     = 1'b1;
            badaddr_d = mem_addr_i;
          end
        end
      end
      ST_WAIT: begin
        if (dm_ack_i) begin
          wb_valid_d = 1'b1;
          wreg_d     = wreg_i && is_load(memop_i);
          wdata_d    = is_load(memop_i) ? ld_data : '0;
        end else if (expire) begin
          wb_valid_d = 1'b1;
          buserr_d   = 1'b1;
        end else begin
          stall_c  = 1'b1;
          dm_req_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Gated by rst_n so an asserted reset releases upstream even with a held memory op.
  assign stall_o    = rst_n && stall_c;
  assign dm_req_o   = dm_req_q;
  assign dm_we_o    = dm_we_q;
  assign dm_sel_o   = dm_sel_q;
  assign dm_addr_o  = dm_addr_q;
  assign dm_wdata_o = dm_wdata_q;
  assign wb_valid_o = wb_valid_q;
  assign wdata_o    = wdata_q;
  assign wd_o       = wd_q;
  assign wreg_o     = wreg_q;
  assign exc_o      = exc_q;
  assign badaddr_o  = badaddr_q;
  assign buserr_o   = buserr_q;

endmodule
